// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch queue.
//               fq_entry_t is one buffered {pc, instr} pair at the default
//               9-bit PC / 32-bit instruction widths.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int FQ_PC_W  = 9;
  localparam int FQ_INS_W = 32;

  typedef struct packed {
    logic [FQ_PC_W-1:0]  pc;
    logic [FQ_INS_W-1:0] instr;
  } fq_entry_t;

  // Byte distance between consecutive instruction words.
  localparam int FETCH_STRIDE = 4;

  // Value presented to decode when nothing is buffered (same as a flush).
  localparam logic [FQ_INS_W-1:0] NOP_INSTR = '0;

endpackage
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fq_fifo
// Description : Synchronous FIFO for fetched {pc, instr} entries.
//               Read data is combinational from the head slot.
//               clear and reset both empty the FIFO in one cycle.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               clear           - synchronous flush (pointers and count to 0)
//               push, wdata     - enqueue at tail (ignored when full w/o pop)
//               pop             - dequeue head (ignored when empty)
//               rdata           - head entry
//               count           - entries currently held
// Revision    : 1.0 - initial release
// ============================================================================
import fetch_pkg::*;

module fq_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t,
  parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    // A push into a full FIFO is legal only when the head leaves in the same
    // cycle; the write then lands in the slot being vacated.
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
    rdata   = mem[rd_ptr];
  end

  // Pointers are log2(DEPTH) bits and wrap on their own; count is kept
  // separately so full and empty are unambiguous.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch front end with a DEPTH-entry prefetch
//               buffer. Owns the fetch PC, issues one read per cycle to a
//               1-cycle-latency synchronous instruction memory, buffers the
//               returned {pc, instr} pairs and flushes on redirect.
// Ports       : clk, reset               - clock, synchronous active-high reset
//               redirect, redirect_pc    - flush and restart fetch at new PC
//               imem_req, imem_addr      - read request to instruction memory
//               imem_rdata               - data for last cycle's request
//               deq_valid/pc/instr       - head of queue towards decode
//               deq_ready                - decode accepts the head
//               count                    - entries currently buffered
// Revision    : 1.0 - initial release
// ============================================================================
import fetch_pkg::*;

module fetch_queue #(
  parameter  int PC_W  = 9,
  parameter  int INS_W = 32,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             deq_valid,
  output logic [PC_W-1:0]  deq_pc,
  output logic [INS_W-1:0] deq_instr,
  input  logic             deq_ready,
  output logic [CNT_W-1:0] count
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;

  logic [PC_W-1:0] issue_addr;
  logic            issue;
  logic [CNT_W:0]  committed;
  logic            push;
  logic            pop;
  entry_t          wr_entry;
  entry_t          head;

  // The low address bits of a redirect target are ignored.
  logic            unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    // Every issued read already owns a slot: buffered entries plus the one
    // in flight must stay below DEPTH. A dequeue this cycle is not credited,
    // which keeps the issue decision independent of deq_ready.
    committed  = {1'b0, count} + (CNT_W + 1)'(inflight);
    issue_addr = redirect ? {redirect_pc[PC_W-1:2], 2'b00} : fetch_pc;
    issue      = !reset && (redirect || (committed < (CNT_W + 1)'(DEPTH)));

    // A response arriving with a redirect belongs to the wrong path.
    push           = inflight && !redirect && !reset;
    wr_entry.pc    = inflight_pc;
    wr_entry.instr = imem_rdata;

    deq_valid = (count != '0);
    pop       = deq_valid && deq_ready && !redirect;
    deq_pc    = deq_valid ? head.pc    : '0;
    deq_instr = deq_valid ? head.instr : INS_W'(NOP_INSTR);

    imem_req  = issue;
    imem_addr = issue_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= '0;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= issue_addr + PC_W'(FETCH_STRIDE);
        inflight_pc <= issue_addr;
      end
    end
  end

  fq_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (redirect),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

endmodule
`default_nettype wire
